// File: rtl/decoder_pkg.sv
// Shared definitions for the serial one-hot decoder: FSM state encoding,
// the default code width and the code-to-one-hot helper.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEFAULT_CODE_W = 2;
   localparam int MAX_CODE_W     = 4;

   // One-hot image of a code value, sized for the widest legal code.
   function automatic logic [15:0] onehot_of(input logic [3:0] code);
      onehot_of = 16'd1 << code;
   endfunction

endpackage

// File: rtl/bit_collector.sv
// Serial collector: shift register (MSB first) plus a count of collected bits.
// 'load' starts a new frame with bit_in; 'shift' appends bit_in.
module bit_collector #(
   parameter int W     = 2,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             bit_in,
   output logic [W-1:0]     code,
   output logic [CNT_W-1:0] cnt
);

   logic [W-1:0] shifted_s;

   // Older bits move towards the MSB; the incoming bit lands in the LSB.
   always_comb begin
      shifted_s = W'({code, bit_in});
   end

   // Shift register and bit counter update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code <= {W{1'b0}};
         cnt  <= {CNT_W{1'b0}};
      end else if (load) begin
         code <= W'(bit_in);
         cnt  <= CNT_W'(1'b1);
      end else if (shift) begin
         code <= shifted_s;
         cnt  <= cnt + CNT_W'(1'b1);
      end else begin
         code <= code;
         cnt  <= cnt;
      end
   end

endmodule

// File: rtl/serial_onehot_decoder.sv
// Serial binary code receiver (MSB first) with one-hot output and a
// valid/ready output handshake. Optional feature macro: PARITY_EN, which
// adds one even-parity bit after the data bits of every frame.
module serial_onehot_decoder
   import decoder_pkg::*;
#(
   parameter int CODE_W = DEFAULT_CODE_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   input  logic                 din_valid,
   input  logic                 start,
   output logic                 din_ready,
   output logic [2**CODE_W-1:0] o,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic                 busy,
   output logic                 err
);

   localparam int OUT_W = 2**CODE_W;
`ifdef PARITY_EN
   localparam int FRAME_W = CODE_W + 1;
`else
   localparam int FRAME_W = CODE_W;
`endif
   localparam int CNT_W = 3;
   localparam bit SINGLE_BIT = (FRAME_W == 1);

   state_t             state_r;
   state_t             state_next_s;
   logic [FRAME_W-1:0] frame_s;
   logic [CNT_W-1:0]   cnt_s;
   logic [FRAME_W-1:0] next_frame_s;
   logic [CODE_W-1:0]  data_code_s;
   logic               parity_ok_s;
   logic [OUT_W-1:0]   decoded_s;
   logic               accept_s;
   logic               load_s;
   logic               shift_s;
   logic               done_s;
   logic               o_load_s;
   logic               o_clear_s;
   logic               err_next_s;

   assign din_ready = (state_r != HOLD);
   assign accept_s  = din_valid & din_ready;

   // Frame contents including the bit being accepted this cycle, so the
   // result can be registered on the same edge as the last bit.
   always_comb begin
      next_frame_s = FRAME_W'({frame_s, din});
`ifdef PARITY_EN
      data_code_s  = next_frame_s[FRAME_W-1:1];
      parity_ok_s  = ~(^next_frame_s);
`else
      data_code_s  = next_frame_s;
      parity_ok_s  = 1'b1;
`endif
      decoded_s    = OUT_W'(onehot_of(4'(data_code_s)));
   end

   bit_collector #(
      .W     (FRAME_W),
      .CNT_W (CNT_W)
   ) u_collector (
      .clk    (clk),
      .rst    (rst),
      .load   (load_s),
      .shift  (shift_s),
      .bit_in (din),
      .code   (frame_s),
      .cnt    (cnt_s)
   );

   // Next-state and control decode.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      shift_s      = 1'b0;
      done_s       = 1'b0;
      o_load_s     = 1'b0;
      o_clear_s    = 1'b0;
      err_next_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s && start) begin
               load_s = 1'b1;
               if (SINGLE_BIT) begin
                  done_s = 1'b1;
               end else begin
                  state_next_s = SHIFT;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            if (accept_s && start) begin
               // A new start aborts the frame and restarts from this bit.
               load_s     = 1'b1;
               err_next_s = 1'b1;
               if (SINGLE_BIT) begin
                  done_s = 1'b1;
               end else begin
                  state_next_s = SHIFT;
               end
            end else if (accept_s) begin
               shift_s = 1'b1;
               if (cnt_s == CNT_W'(FRAME_W - 1)) begin
                  done_s = 1'b1;
               end else begin
                  state_next_s = SHIFT;
               end
            end else begin
               state_next_s = SHIFT;
            end
         end
         HOLD: begin
            if (o_ready) begin
               o_clear_s    = 1'b1;
               state_next_s = IDLE;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      if (done_s) begin
         if (parity_ok_s) begin
            o_load_s     = 1'b1;
            state_next_s = HOLD;
         end else begin
            err_next_s   = 1'b1;
            state_next_s = IDLE;
         end
      end else begin
         o_load_s = 1'b0;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         o       <= {OUT_W{1'b0}};
         o_valid <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy    <= (state_next_s != IDLE);
         err     <= err_next_s;
         if (o_load_s) begin
            o       <= decoded_s;
            o_valid <= 1'b1;
         end else if (o_clear_s) begin
            o       <= o;
            o_valid <= 1'b0;
         end else begin
            o       <= o;
            o_valid <= o_valid;
         end
      end
   end

endmodule

// File: doc/serial_onehot_decoder.md
Name: serial_onehot_decoder

Overview:
Receive side of the encoder path. Collects a serially transmitted binary code, MSB first, one bit per accepted cycle. Decodes the code to a one-hot vector and presents it with a valid/ready handshake. With CODE_W=1 it is the 1-to-2 inverse of the 2:1 encoder. The default build is a 2-to-4 decoder.

Parameters:
CODE_W, 2, code width in bits; output width is 2**CODE_W; legal range 1..4

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
din  in  1  serial code bit, MSB first
din_valid  in  1  din is valid this cycle
start  in  1  qualifies din as the first bit of a frame (used only with din_valid)
din_ready  out  1  block accepts din; equals 1 in IDLE and SHIFT, 0 in HOLD (combinational from state)
o  out  2**CODE_W  one-hot decoded value, registered
o_valid  out  1  o holds a new, unconsumed result
o_ready  in  1  downstream consumes o
busy  out  1  a frame is in progress (state SHIFT or HOLD)
err  out  1  one-cycle pulse on a framing error (also parity error when PARITY_EN is defined)

Behaviour:
- Reset (async, any state):
  - state goes to IDLE; the shift register and bit counter are cleared.
  - o=0, o_valid=0, busy=0, err=0, din_ready=1.
  - A partial frame is discarded; no output is produced for it.
- A bit is accepted only when din_valid=1 and din_ready=1.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - Accepted bit with start=1: load the bit, set cnt=1. Go to HOLD if cnt==CODE_W, else go to SHIFT.
  - Accepted bit with start=0: ignored, no err.
- SHIFT:
  - Accepted bit with start=0: shift it in, cnt++. When cnt reaches CODE_W, go to HOLD.
  - Accepted bit with start=1: abort the current frame, pulse err for one cycle, restart with this bit as bit 0 (cnt=1).
  - No din_valid: hold state; there is no timeout.
- Entry to HOLD (same clock edge as the last data bit is accepted):
  - o <= 1 << code; o_valid <= 1.
  - Latency: o and o_valid are visible the cycle after the last bit is accepted.
- HOLD:
  - o_valid stays 1 and o is stable until o_ready=1.
  - din is ignored because din_ready=0.
  - On the edge where o_ready=1: o_valid <= 0, go to IDLE. The next frame can be accepted from the following cycle.
- o retains its last decoded value after the handshake. Only a new completed frame or a reset changes o.
- Code to output mapping: first bit received is code[CODE_W-1]. Code value k drives o[k]=1. o is exactly one-hot whenever o_valid=1.
- o_ready while not in HOLD: no effect.
- Simultaneous err and frame completion cannot occur, because err is raised only by a restart.

Optional Feature:
PARITY_EN defined:
- Each frame carries one extra even-parity bit after the CODE_W data bits. The state stays in SHIFT until cnt==CODE_W+1.
- Parity OK (XOR of data and parity bits == 0): enter HOLD as normal.
- Parity mismatch: err pulses one cycle, go to IDLE, o and o_valid unchanged.
- Latency counts from acceptance of the parity bit.

PARITY_EN undefined:
- No parity bit; err only flags a start during SHIFT.

Decomposition:
- Shared package/header decoder_pkg holds:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2.
  - default CODE_W.
  - an onehot_of(code) function, reused by the bench as the reference model.
- One natural sub-module, bit_collector: shift register plus bit counter, with inputs load, shift, bit and outputs code, cnt.
- The FSM and output registers stay in the top level.

Test Plan:
All scenarios use CODE_W=2.
- Basic decode: reset, then bits (start=1,din=1), (start=0,din=0) on consecutive cycles -> next cycle o=4'b0100, o_valid=1, busy=1.
- Backpressure: hold o_ready=0 for 5 cycles while driving din_valid=1 -> o_valid stays 1, o=4'b0100, din_ready=0, no bits taken. Raise o_ready=1 -> o_valid=0 and IDLE next cycle, then a new frame 1,1 -> o=4'b1000.
- Abort/restart: bits (start=1,din=1) then (start=1,din=0) then (start=0,din=1) -> err high exactly one cycle on the second bit, then o=4'b0010.
- Stray data in IDLE: din_valid=1, start=0 for 4 cycles -> busy=0, o_valid=0, err=0, o unchanged.
- Reset mid-frame: assert rst after the first bit, asynchronously off a clock edge -> o=0, o_valid=0, busy=0 immediately. Next frame 0,1 -> o=4'b0010.
- PARITY_EN: frame 1,1,1 -> err pulse, no o_valid, o unchanged. Frame 1,1,0 -> o=4'b1000, o_valid=1.
